// File: rtl/bsg_lss_tx_ctrl_pkg.sv
// Shared types for the launch-side sequencer of a bsg_launch_sync_sync crossing.
// Holds the FSM state encoding used by bsg_launch_sync_sync_tx_ctrl.
package bsg_lss_tx_ctrl_pkg;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] StIdleEnc    = 2'b00;
  localparam logic [StateW-1:0] StSetupEnc   = 2'b01;
  localparam logic [StateW-1:0] StWaitAckEnc = 2'b10;

  typedef enum logic [StateW-1:0] {
    StIdle    = StIdleEnc,
    StSetup   = StSetupEnc,
    StWaitAck = StWaitAckEnc
  } state_e;

endpackage

// File: rtl/bsg_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset.
// Ports:
//   clk_i    destination clock
//   reset_i  asynchronous active-high reset, clears both stages
//   d_i      asynchronous input
//   q_o      synchronized output (two clk_i edges after d_i settles)
module bsg_sync_2ff #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] meta_q;
  logic [width_p-1:0] sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bsg_launch_sync_sync_tx_ctrl.sv
// Launch-side sequencer for a bsg_launch_sync_sync crossing. Accepts a word on a valid/ready
// port, holds it in a launch register, toggles a 2-phase request after setup_p cycles, then
// waits for the far side's synchronized 2-phase ack before accepting another word.
// Ports:
//   clk_i, reset_i   clock and asynchronous active-high reset
//   v_i, data_i      input word and its valid; accepted when v_i & ready_o
//   ready_o          high in IDLE (and never during reset)
//   launch_data_o    registered word feeding the crossing's data flops
//   launch_req_o     registered 2-phase request toggle
//   ack_toggle_i     far-side 2-phase ack, asynchronous to clk_i
//   busy_o           transfer in flight
//   err_o            sticky timeout flag, cleared by clear_err_i
module bsg_launch_sync_sync_tx_ctrl
  import bsg_lss_tx_ctrl_pkg::*;
#(
  parameter int unsigned width_p   = 32,
  parameter int unsigned setup_p   = 2,
  parameter int unsigned timeout_p = 256
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic [width_p-1:0] launch_data_o,
  output logic               launch_req_o,
  input  logic               ack_toggle_i,
  output logic               busy_o,
  output logic               err_o,
  input  logic               clear_err_i
);

  localparam int unsigned SetupCntW = (setup_p > 1) ? $clog2(setup_p) : 1;
  localparam int unsigned WaitCntW  = $clog2(timeout_p + 1);

  state_e                 state_q, state_d;
  logic [width_p-1:0]     data_q, data_d;
  logic                   req_q, req_d;
  logic [SetupCntW-1:0]   cnt_q, cnt_d;
  logic [WaitCntW-1:0]    wcnt_q, wcnt_d;
  logic                   err_q, err_d;
  logic                   ack_s;

  // Only the synchronized ack is ever looked at; the raw toggle feeds nothing else.
  bsg_sync_2ff #(
    .width_p(1)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (ack_toggle_i),
    .q_o    (ack_s)
  );

  assign ready_o       = (state_q == StIdle) && !reset_i;
  assign busy_o        = (state_q != StIdle);
  assign launch_data_o = data_q;
  assign launch_req_o  = req_q;
  assign err_o         = err_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;

    if (clear_err_i) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (v_i && ready_o) begin
          data_d  = data_i;
          cnt_d   = SetupCntW'(setup_p - 1);
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          req_d   = ~req_q;
          wcnt_d  = '0;
          state_d = StWaitAck;
        end else begin
          cnt_d = cnt_q - SetupCntW'(1);
        end
      end
      StWaitAck: begin
        if (ack_s == req_q) begin
          state_d = StIdle;
        end else if (wcnt_q < WaitCntW'(timeout_p)) begin
          wcnt_d = wcnt_q + WaitCntW'(1);
          // Set is applied after clear so a coincident clear loses.
          if (wcnt_q == WaitCntW'(timeout_p - 1)) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

endmodule
